// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter
//   Shares one single-ported main memory among N_PORTS requesters. One access
//   is in flight at a time. A requester holds its request until it sees a
//   one-cycle ac pulse.
//
//   Build option: define MAIN_MEM_ARB_RR_EN for round-robin arbitration.
//   Without it, the lowest index wins and ptr is a constant 0.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset_n    in   synchronous, active-low reset
//   req_read   in   [N_PORTS]          per-port read request
//   req_write  in   [N_PORTS]          per-port write request (wins over read)
//   req_adr    in   [N_PORTS*ADDR_W]   per-port address, port i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   [N_PORTS*DATA_W]   per-port write data, port i at [i*DATA_W +: DATA_W]
//   ac         out  [N_PORTS]          one-cycle acknowledge for the finished access
//   rdata      out  [DATA_W]           read data, valid while the matching ac bit is high
//   mem_adr    out  [ADDR_W]           memory address (0 when idle)
//   mem_wdata  out  [DATA_W]           memory write data (0 when idle)
//   mem_we     out                     memory write enable, first ACCESS cycle of a write
//   mem_rdata  in   [DATA_W]           memory read data
module main_mem_arbiter #(
   parameter int unsigned N_PORTS = 4,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [N_PORTS-1:0]          req_read,
   input  logic [N_PORTS-1:0]          req_write,
   input  logic [N_PORTS*ADDR_W-1:0]   req_adr,
   input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
   output logic [N_PORTS-1:0]          ac,
   output logic [DATA_W-1:0]           rdata,
   output logic [ADDR_W-1:0]           mem_adr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_we,
   input  logic [DATA_W-1:0]           mem_rdata
);

   localparam int unsigned SEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
   localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(N_PORTS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   sel, sel_nxt;
   logic               wr_q, wr_nxt;
   logic               first_q, first_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [DATA_W-1:0]  rdata_q, rdata_nxt;
   logic [SEL_W-1:0]   ptr;

   logic [N_PORTS-1:0] req_any;
   logic [N_PORTS-1:0] excl;
   logic [N_PORTS-1:0] cand;
   logic               grant_vld;
   logic [SEL_W-1:0]   grant;
   logic               take;

   assign req_any = req_read | req_write;
   assign rdata   = rdata_q;

   // The port finishing in ACK is not eligible that cycle; it can only be
   // granted again through IDLE.
   always_comb begin
      excl = '0;
      if (state == ACK) begin
         excl[sel] = 1'b1;
      end
   end

   assign cand = req_any & ~excl;

   // Search starts at ptr and wraps modulo N_PORTS.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant     = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N_PORTS) begin
            idx = idx - N_PORTS;
         end
         if (!grant_vld && cand[SEL_W'(idx)]) begin
            grant_vld = 1'b1;
            grant     = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      wr_nxt    = wr_q;
      first_nxt = first_q;
      cnt_nxt   = cnt;
      rdata_nxt = rdata_q;
      take      = 1'b0;
      ac        = '0;
      mem_we    = 1'b0;
      mem_adr   = '0;
      mem_wdata = '0;

      case (state)
         IDLE: begin
            if (grant_vld) begin
               take = 1'b1;
            end
         end
         ACCESS: begin
            mem_adr   = req_adr[sel*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[sel*DATA_W +: DATA_W];
            mem_we    = wr_q & first_q;
            first_nxt = 1'b0;
            if (cnt == '0) begin
               if (!wr_q) begin
                  rdata_nxt = mem_rdata;
               end
               state_nxt = ACK;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ACK: begin
            ac[sel] = 1'b1;
            if (grant_vld) begin
               take = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (take) begin
         state_nxt = ACCESS;
         sel_nxt   = grant;
         wr_nxt    = req_write[grant];
         first_nxt = 1'b1;
         cnt_nxt   = CNT_INIT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         sel     <= '0;
         wr_q    <= 1'b0;
         first_q <= 1'b0;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         wr_q    <= wr_nxt;
         first_q <= first_nxt;
         cnt     <= cnt_nxt;
         rdata_q <= rdata_nxt;
      end
   end

`ifdef MAIN_MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (take) begin
         ptr <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
      end
   end
`else
   assign ptr = '0;
`endif

endmodule

// File: tb/tb_main_mem_arbiter.sv
`timescale 1ns/1ps
module tb_main_mem_arbiter;

   localparam int N   = 4;
   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      req_read, req_write;
   logic [N*AW-1:0]   req_adr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      ac;
   logic [DW-1:0]     rdata;
   logic [AW-1:0]     mem_adr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_we;
   logic [DW-1:0]     mem_rdata;

   main_mem_arbiter #(
      .N_PORTS (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .MEM_LAT (LAT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_read  (req_read),
      .req_write (req_write),
      .req_adr   (req_adr),
      .req_wdata (req_wdata),
      .ac        (ac),
      .rdata     (rdata),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: one registered read stage, write on mem_we.
   logic [DW-1:0] mem_model [0:255];
   logic          init_mem;
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) mem_model[i] <= 16'(16'hA000 + i);
         mem_model[8'h10] <= 16'hBEEF;
         mem_rdata <= '0;
      end else begin
         if (mem_we) mem_model[mem_adr[7:0]] <= mem_wdata;
         mem_rdata <= mem_model[mem_adr[7:0]];
      end
   end

   typedef struct {
      int          port;
      logic [15:0] data;
      bit          chk;
      int          cyc;
   } ack_t;

   typedef struct {
      logic [15:0] adr;
      logic [15:0] data;
      int          cyc;
   } wr_t;

   ack_t ack_q[$];
   wr_t  wr_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: pops the scoreboard whenever the DUT acknowledges or writes.
   ack_t mon_a;
   wr_t  mon_w;
   always @(negedge clk) begin
      if (ac != '0) begin
         if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ac: got ac=%b at cycle %0d, expected none", ac, cyc);
         end else begin
            mon_a = ack_q.pop_front();
            check("ac_vector", 32'(ac), 32'(4'b0001 << mon_a.port));
            check("ac_cycle", cyc, mon_a.cyc);
            if (mon_a.chk) check("rdata", 32'(rdata), 32'(mon_a.data));
         end
      end
      if (mem_we) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_we: got mem_we=1 adr=%0h at cycle %0d, expected 0", mem_adr, cyc);
         end else begin
            mon_w = wr_q.pop_front();
            check("mem_we_adr", 32'(mem_adr), 32'(mon_w.adr));
            check("mem_we_data", 32'(mem_wdata), 32'(mon_w.data));
            check("mem_we_cycle", cyc, mon_w.cyc);
         end
      end
   end

   task automatic set_req(input int p, input bit rd, input bit wr,
                          input logic [15:0] adr, input logic [15:0] wd);
      req_read[p]            = rd;
      req_write[p]           = wr;
      req_adr[p*AW +: AW]    = adr;
      req_wdata[p*DW +: DW]  = wd;
   endtask

   task automatic wait_ack(input int p);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ac[p] && n < 40);
      check($sformatf("ack_seen_p%0d", p), 32'(ac[p]), 32'd1);
   endtask

   task automatic push_ack(input int p, input logic [15:0] d, input bit chk, input int c);
      ack_t a;
      a.port = p; a.data = d; a.chk = chk; a.cyc = c;
      ack_q.push_back(a);
   endtask

   task automatic single(input int p, input bit rd, input bit wr, input logic [15:0] adr,
                         input logic [15:0] wd, input logic [15:0] exp_d, input bit chk);
      int  c;
      wr_t w;
      @(posedge clk); #1;
      c = cyc;
      if (wr) begin
         w.adr = adr; w.data = wd; w.cyc = c + 1;
         wr_q.push_back(w);
      end
      push_ack(p, exp_d, chk, c + LAT + 1);
      set_req(p, rd, wr, adr, wd);
      wait_ack(p);
      @(posedge clk); #1;
      set_req(p, 1'b0, 1'b0, adr, wd);
   endtask

   int c0;
   int order [6];

   initial begin
      reset_n   = 1'b0;
      init_mem  = 1'b1;
      req_read  = '0;
      req_write = '0;
      req_adr   = '0;
      req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      init_mem = 1'b0;

      @(negedge clk);
      check("reset_ac", 32'(ac), 32'd0);
      check("reset_mem_we", 32'(mem_we), 32'd0);
      check("reset_mem_adr", 32'(mem_adr), 32'd0);
      check("reset_mem_wdata", 32'(mem_wdata), 32'd0);

      single(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1);
      single(2, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0);
      single(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b1);
      // read and write both high: a write
      single(0, 1'b1, 1'b1, 16'h0030, 16'h5A5A, 16'h0000, 1'b0);
      single(3, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A, 1'b1);

      // Port 3 drops its read in the first ACCESS cycle; ac still pulses.
      @(posedge clk); #1;
      c0 = cyc;
      push_ack(3, 16'hA050, 1'b1, c0 + LAT + 1);
      set_req(3, 1'b1, 1'b0, 16'h0050, 16'h0000);
      @(posedge clk); #1;
      req_read[3] = 1'b0;
      wait_ack(3);
      @(negedge clk);
      check("idle_after_drop_mem_adr", 32'(mem_adr), 32'd0);

      // All four ports request continuously.
`ifdef MAIN_MEM_ARB_RR_EN
      order = '{0, 1, 2, 3, 0, 1};
`else
      order = '{0, 1, 0, 1, 0, 1};
`endif
      @(posedge clk); #1;
      c0 = cyc;
      for (int k = 0; k < 6; k++)
         push_ack(order[k], 16'(16'hA040 + order[k]), 1'b1, c0 + (k + 1) * (LAT + 1));
      for (int p = 0; p < N; p++)
         set_req(p, 1'b1, 1'b0, 16'(16'h0040 + p), 16'h0000);
      for (int k = 0; k < 5; k++) wait_ack(order[k]);
      @(posedge clk); #1;
      req_read = '0;
      wait_ack(order[5]);

      // Reset in the second ACCESS cycle of a read aborts it.
      @(posedge clk); #1;
      set_req(2, 1'b1, 1'b0, 16'h0060, 16'h0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n     = 1'b1;
      req_read[2] = 1'b0;
      @(negedge clk);
      check("abort_ac", 32'(ac), 32'd0);
      check("abort_mem_we", 32'(mem_we), 32'd0);
      check("abort_mem_adr", 32'(mem_adr), 32'd0);

      // ptr back at 0: port 1 is served before port 3.
      @(posedge clk); #1;
      c0 = cyc;
      push_ack(1, 16'hA061, 1'b1, c0 + LAT + 1);
      push_ack(3, 16'hA062, 1'b1, c0 + 2 * (LAT + 1));
      set_req(1, 1'b1, 1'b0, 16'h0061, 16'h0000);
      set_req(3, 1'b1, 1'b0, 16'h0062, 16'h0000);
      wait_ack(1);
      @(posedge clk); #1;
      req_read[1] = 1'b0;
      wait_ack(3);
      @(posedge clk); #1;
      req_read[3] = 1'b0;

      repeat (6) @(negedge clk);
      check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      check("write_queue_drained", 32'(wr_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

- Shares the single-ported main memory among `N_PORTS` requesters, e.g. per-core instruction fetch and MEM-stage data ports.
- Each requester raises a read or write request and holds it stable until it sees a one-cycle acknowledge. The pipeline hazard unit treats `request & !ac` as a memory stall, so the arbiter alone decides when each pipeline may advance.
- Sits between the core pipelines and the memory macro.
- One access is in flight at a time. Arbitration is round-robin.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesters (≥2).
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_LAT`, 2: cycles from address presented to `mem_rdata` valid (≥1).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_read`  in  `N_PORTS`  per-port read request.
- `req_write`  in  `N_PORTS`  per-port write request.
- `req_adr`  in  `N_PORTS`×`ADDR_W`  per-port address.
- `req_wdata`  in  `N_PORTS`×`DATA_W`  per-port write data.
- `ac`  out  `N_PORTS`  per-port one-cycle acknowledge.
- `rdata`  out  `DATA_W`  read data, valid while the matching `ac` bit is high.
- `mem_adr`  out  `ADDR_W`  memory address.
- `mem_wdata`  out  `DATA_W`  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  `DATA_W`  memory read data.

## Operation
- **Request rules**
  - Port i requests when `req_read[i] | req_write[i]`.
  - If both are high, the access is a write.
  - Requesters hold address, data and type stable until `ac[i]`.
- **State machine**: IDLE, ACCESS, ACK.
  - **IDLE**: if any port requests, pick winner `g`, latch `sel<=g`, type and `cnt<=MEM_LAT-1`, go to ACCESS. Otherwise stay.
  - **ACCESS**:
    - Drive `mem_adr=req_adr[sel]` and `mem_wdata=req_wdata[sel]`.
    - `mem_we=1` only in the first ACCESS cycle of a write.
    - If `cnt==0`: latch `rdata_q<=mem_rdata` (reads), go to ACK. Otherwise decrement `cnt`.
  - **ACK**:
    - `ac[sel]=1` and `rdata=rdata_q`.
    - Arbitrate among requesting ports excluding `sel`. A winner goes straight to ACCESS (back-to-back). No winner goes to IDLE.
- **Arbitration**
  - Round-robin pointer `ptr`. Search starts at `ptr`, wraps modulo `N_PORTS`.
  - On every grant, `ptr<=g+1` (mod `N_PORTS`, wraps `N_PORTS-1`→0).
- **Dropped requests**: if a requester drops its request mid-access (pipeline flush), the access still completes and `ac` still pulses. A started write is committed.
- **Port outputs**: `ac` is never asserted for more than one port or for more than one cycle per grant.
- **Idle outputs**: `rdata` is `rdata_q` at all times (don't-care outside `ac`). `mem_adr` and `mem_wdata` are 0 in IDLE.

## Timing
- **Reset** (`reset_n`=0 at an edge): state=IDLE, `ac`=0, `mem_we`=0, `mem_adr`=0, `mem_wdata`=0, `rdata_q`=0, `ptr`=0, `cnt`=0.
  - Reset mid-access aborts it with no `ac`.
  - A write whose `mem_we` cycle already occurred stays written.
- **Latency**: request seen in IDLE at cycle 0 → ACCESS cycles 1..`MEM_LAT` → `ac` in cycle `MEM_LAT`+1.
- **Throughput**: back-to-back grants from ACK give one completed access every `MEM_LAT`+1 cycles under continuous load.
- **Outputs**: `ac` and `mem_we` are registered-state decodes with no combinational path from `req_*`. `mem_adr` and `mem_wdata` are muxed from `req_*` by registered `sel`.
- **Simultaneous events**: a request from `sel` during ACK is ignored that cycle, since it is the finishing request. The same port may be granted again next cycle only via IDLE.

## Configuration
- Macro: `MAIN_MEM_ARB_RR_EN`.
  - **Defined**: round-robin arbitration with `ptr` as described.
  - **Undefined**: fixed priority, lowest index wins. `ptr` is not implemented (reads as 0). The ACK-state exclusion of `sel` still applies.

## Test plan
- Reset, then port 1 read at adr 0x0010 with mem returning 0xBEEF (`MEM_LAT`=2) → `ac[1]` exactly in cycle 3, `rdata`=0xBEEF, other `ac` bits 0.
- Port 2 write 0x1234 to 0x0020 → `mem_we`=1 for exactly one cycle with that adr/data, `ac[2]` in cycle 3; a following read of 0x0020 returns 0x1234.
- Ports 0-3 all request continuously (RR build) → grants 0,1,2,3,0, `ac` pulses every 3 cycles, no gaps.
- Same stimulus with `MAIN_MEM_ARB_RR_EN` undefined and port 0 re-requesting after each `ac` → port 0 and port 1 alternate; ports 2 and 3 starve.
- Port 3 drops its read in cycle 1 of ACCESS → `ac[3]` still pulses in cycle 3, then IDLE.
- `reset_n`=0 in cycle 2 of a read → next cycle IDLE, all `ac`=0, `mem_we`=0, `ptr`=0.
